// File: rtl/imem_loader_if.sv
// Handshake and write-port bundle between the byte-stream source, the program loader and the imem.
// The slave modport is the loader's view; the master modport is the stream source / observer view.
interface imem_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_hold;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, core_hold
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, busy, done, err, core_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: takes a framed byte stream (16-bit length, payload, 8-bit additive checksum)
// and writes the payload little-endian into a byte-writable imem, holding the core meanwhile.
module imem_loader #(
  parameter int DEPTH   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [15:0]      DEPTH16  = 16'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        csum_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [31:0]       mem_waddr_q;
  logic [7:0]        mem_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [15:0]       len_full_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [7:0]        csum_d;
  logic              tmo_hit;

  assign accept     = bus.in_valid & in_ready_q;
  assign len_full_d = {bus.in_data, len_lo_q};
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign csum_d     = csum_q + bus.in_data;
  assign tmo_hit    = busy_q && !accept && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;

      // Idle-gap counter runs only during a load and restarts on every accepted byte.
      if (busy_q) begin
        if (accept) begin
          tmo_q <= '0;
        end else begin
          tmo_q <= tmo_q + TMO_W'(1);
        end
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            state_q    <= S_LEN_LO;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            csum_q     <= '0;
            tmo_q      <= '0;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_lo_q <= bus.in_data;
            state_q  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q <= len_full_d;
            if (len_full_d > DEPTH16) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else if (len_full_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= {{(32-CNT_W){1'b0}}, cnt_q};
            mem_wdata_q <= bus.in_data;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            if ({{(16-CNT_W){1'b0}}, cnt_d} == len_q) begin
              state_q <= S_CSUM;
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase

      // A stalled stream aborts the load; no accept this cycle, so no write is in flight.
      if (tmo_hit) begin
        state_q    <= S_ERR;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
        err_q      <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.core_hold = busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed loads at the falling edge, captures writes at the
// falling edge, and checks outputs and the write sequence against hand-computed values.
module tb_imem_loader;

  localparam int DEPTH   = 128;
  localparam int TIMEOUT = 1024;

  logic clk;
  logic rst_n;
  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [7:0]  tb_mem[DEPTH];

  logic [7:0] prog[8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h93, 8'h03, 8'h10, 8'h00};
  logic [7:0] quad[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_waddr);
      wr_data.push_back(bus.mem_wdata);
      tb_mem[bus.mem_waddr[6:0]] = bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the start edge.
  task automatic pulse_start(input logic with_byte, input logic [7:0] b);
    wr_addr.delete();
    wr_data.delete();
    bus.start = 1'b1;
    if (with_byte) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b;
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Presents one byte and returns at the falling edge after it was accepted.
  task automatic send(input logic [7:0] b, input bit rnd);
    int n;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready_wait", 32'(n >= 20), 32'd0);
    @(negedge clk);
  endtask

  task automatic load_prog(input logic [7:0] csum, input bit rnd);
    send(8'h08, rnd);
    send(8'h00, rnd);
    for (int i = 0; i < 8; i++) send(prog[i], rnd);
    send(csum, rnd);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_prog_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
      check($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(prog[i]));
    end
  endtask

  task automatic report(input string tag);
    $display("[TB] load %s: writes=%0d done=%0b err=%0b busy=%0b", tag, wr_addr.size(),
             bus.done, bus.err, bus.busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nbad;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_waddr",     bus.mem_waddr,      32'd0);
    check("rst_wdata",     32'(bus.mem_wdata), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_core_hold", 32'(bus.core_hold), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good 8-byte load; checksum = mod-256 sum of payload = 0x89.
    pulse_start(1'b0, 8'h00);
    check("t1_busy_after_start", 32'(bus.busy),      32'd1);
    check("t1_hold_after_start", 32'(bus.core_hold), 32'd1);
    check("t1_ready_after_start",32'(bus.in_ready),  32'd1);
    load_prog(8'h89, 1'b0);
    report("good8");
    check("t1_done",  32'(bus.done),      32'd1);
    check("t1_err",   32'(bus.err),       32'd0);
    check("t1_busy",  32'(bus.busy),      32'd0);
    check("t1_hold",  32'(bus.core_hold), 32'd0);
    check("t1_ready", 32'(bus.in_ready),  32'd0);
    check_prog_writes("t1");
    check("t1_word0", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h0050_0093);
    check("t1_word1", {tb_mem[7], tb_mem[6], tb_mem[5], tb_mem[4]}, 32'h0010_0393);

    // Same stream, wrong checksum.
    pulse_start(1'b0, 8'h00);
    load_prog(8'h8A, 1'b0);
    report("badcsum");
    check("t2_err",  32'(bus.err),  32'd1);
    check("t2_done", 32'(bus.done), 32'd0);
    check_prog_writes("t2");

    // Oversize length 129.
    pulse_start(1'b0, 8'h00);
    send(8'h81, 1'b0);
    send(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    report("oversize");
    check("t3_err",   32'(bus.err),      32'd1);
    check("t3_done",  32'(bus.done),     32'd0);
    check("t3_ready", 32'(bus.in_ready), 32'd0);
    check("t3_busy",  32'(bus.busy),     32'd0);
    check("t3_nwr",   32'(wr_addr.size()), 32'd0);

    // Length exactly DEPTH: bytes 0..127, checksum 8128 mod 256 = 0xC0.
    pulse_start(1'b0, 8'h00);
    send(8'h80, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0);
    send(8'hC0, 1'b0);
    bus.in_valid = 1'b0;
    report("full");
    check("td_done", 32'(bus.done), 32'd1);
    check("td_nwr",  32'(wr_addr.size()), 32'd128);
    if (wr_addr.size() == 128) begin
      check("td_last_addr", wr_addr[127], 32'd127);
      check("td_last_data", 32'(wr_data[127]), 32'h7F);
    end
    nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== 8'(i)) nbad++;
    check("td_mem_bad_bytes", 32'(nbad), 32'd0);

    // Zero length; the byte offered together with start must not be consumed as len_lo.
    pulse_start(1'b1, 8'h05);
    check("t4_ready", 32'(bus.in_ready), 32'd1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    report("zero");
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_err",  32'(bus.err),  32'd0);
    check("t4_nwr",  32'(wr_addr.size()), 32'd0);

    // Good load again with random gaps on in_valid.
    pulse_start(1'b0, 8'h00);
    load_prog(8'h89, 1'b1);
    report("gappy");
    check("tr_done", 32'(bus.done), 32'd1);
    check("tr_err",  32'(bus.err),  32'd0);
    check_prog_writes("tr");

    // Stall after three payload bytes.
    pulse_start(1'b0, 8'h00);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send(prog[i], 1'b0);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.err !== 1'b1 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    report("stall");
    check("t5_stall_cycles", 32'(n), 32'(TIMEOUT));
    check("t5_err",  32'(bus.err),  32'd1);
    check("t5_done", 32'(bus.done), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_nwr",  32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++)
      check($sformatf("t5_addr%0d", i), wr_addr[i], 32'(i));

    // Asynchronous reset between edges while a write is on the port.
    pulse_start(1'b0, 8'h00);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(prog[0], 1'b0);
    send(prog[1], 1'b0);
    check("t6_we_before_rst", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("t6_rst_we",    32'(bus.mem_we),    32'd0);
    check("t6_rst_busy",  32'(bus.busy),      32'd0);
    check("t6_rst_hold",  32'(bus.core_hold), 32'd0);
    check("t6_rst_ready", 32'(bus.in_ready),  32'd0);
    check("t6_rst_waddr", bus.mem_waddr,      32'd0);
    repeat (2) @(negedge clk);
    check("t6_nwr_after_rst", 32'(wr_addr.size()), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_ready", 32'(bus.in_ready), 32'd0);
    pulse_start(1'b0, 8'h00);
    send(8'h04, 1'b0);
    send(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send(quad[i], 1'b0);
    send(8'hAA, 1'b0);
    bus.in_valid = 1'b0;
    report("after_rst");
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_err",  32'(bus.err),  32'd0);
    check("t6_nwr",  32'(wr_addr.size()), 32'd4);
    check("t6_word0", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 32'h4433_2211);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
